// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares the memory-mapped UART transmit path between
// NUM_REQ byte-stream requesters. For every byte it polls the UART status register
// and writes the data register only once TX is not full. A grant lasts up to
// MAX_BURST bytes or until the requester's last byte.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ                = 4,
    parameter int unsigned MAX_BURST              = 8,
    parameter logic [31:0] MMIO_UART_BASE_ADDRESS = 32'h1000_0000,
    parameter logic [31:0] MMIO_UART_GET_STATUS   = 32'h0000_0008,
    parameter logic [31:0] MMIO_UART_WRITE_DATA   = 32'h0000_0004,
    localparam int unsigned IdW                   = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   io_bus_m_rd_en,
    output logic                   io_bus_m_wr_en,
    output logic [31:0]            io_bus_m_address,
    output logic [31:0]            io_bus_m_wr_data,
    input  logic [31:0]            io_bus_m_rd_data,
    output logic                   busy,
    output logic [IdW-1:0]         grant_id
);

    localparam logic [31:0]    StatusAddr = MMIO_UART_BASE_ADDRESS | MMIO_UART_GET_STATUS;
    localparam logic [31:0]    DataAddr   = MMIO_UART_BASE_ADDRESS | MMIO_UART_WRITE_DATA;
    localparam logic [7:0]     MaxBurst8  = 8'(MAX_BURST);
    localparam logic [IdW-1:0] LastId     = IdW'(NUM_REQ - 1);
    localparam int unsigned    CntW       = IdW + 1;

    typedef enum logic [2:0] {
        StIdle,
        StPoll,
        StCheck,
        StWrite,
        StRelease
    } state_e;

    state_e         state_q, state_d;
    logic [IdW-1:0] grant_q, grant_d;
    logic [IdW-1:0] rr_ptr_q, rr_ptr_d;
    logic [7:0]     byte_cnt_q, byte_cnt_d;
    logic [7:0]     byte_cnt_inc;

    logic           pick_found;
    logic [IdW-1:0] pick_id;
    logic [CntW-1:0] cand_sum;

    logic [7:0]     req_byte [NUM_REQ];

    // Only tx_full of the status word matters; the rest is read but ignored.
    logic           rd_data_unused;
    logic           tx_full;

    assign tx_full        = io_bus_m_rd_data[3];
    assign rd_data_unused = ^{io_bus_m_rd_data[31:4], io_bus_m_rd_data[2:0]};

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_byte
        assign req_byte[gi] = req_data[8*gi +: 8];
    end

    assign byte_cnt_inc = byte_cnt_q + 8'd1;
    assign busy         = (state_q != StIdle);
    assign grant_id     = grant_q;

    // Pick the first valid requester at or after rr_ptr, wrapping around.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        cand_sum   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand_sum = {1'b0, rr_ptr_q} + CntW'(k);
            if (cand_sum >= CntW'(NUM_REQ)) begin
                cand_sum = cand_sum - CntW'(NUM_REQ);
            end
            if (!pick_found && req_valid[cand_sum[IdW-1:0]]) begin
                pick_found = 1'b1;
                pick_id    = cand_sum[IdW-1:0];
            end
        end
    end

    // Sequencer next state and bus/handshake outputs.
    always_comb begin
        state_d          = state_q;
        grant_d          = grant_q;
        rr_ptr_d         = rr_ptr_q;
        byte_cnt_d       = byte_cnt_q;
        io_bus_m_rd_en   = 1'b0;
        io_bus_m_wr_en   = 1'b0;
        io_bus_m_address = '0;
        io_bus_m_wr_data = '0;
        req_ready        = '0;

        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    grant_d    = pick_id;
                    byte_cnt_d = '0;
                    state_d    = StPoll;
                end
            end
            StPoll: begin
                io_bus_m_rd_en   = 1'b1;
                io_bus_m_address = StatusAddr;
                state_d          = StCheck;
            end
            StCheck: begin
                io_bus_m_address = StatusAddr;
                if (tx_full) begin
                    state_d = StPoll;
                end else if (!req_valid[grant_q]) begin
                    // Requester withdrew; give up the grant without writing.
                    state_d = StRelease;
                end else begin
                    state_d = StWrite;
                end
            end
            StWrite: begin
                io_bus_m_wr_en     = 1'b1;
                io_bus_m_address   = DataAddr;
                io_bus_m_wr_data   = {24'h0, req_byte[grant_q]};
                req_ready[grant_q] = 1'b1;
                byte_cnt_d         = byte_cnt_inc;
                if (req_last[grant_q] || byte_cnt_inc == MaxBurst8) begin
                    state_d = StRelease;
                end else begin
                    state_d = StPoll;
                end
            end
            StRelease: begin
                rr_ptr_d = (grant_q == LastId) ? '0 : grant_q + 1'b1;
                state_d  = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // A byte pending when reset arrives must not be written or accepted.
        if (rst) begin
            io_bus_m_rd_en   = 1'b0;
            io_bus_m_wr_en   = 1'b0;
            io_bus_m_address = '0;
            io_bus_m_wr_data = '0;
            req_ready        = '0;
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            byte_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            byte_cnt_q <= byte_cnt_d;
        end
    end

endmodule
